// File: rtl/nodf_module_status_tracker.sv
// Status tracker for one non-dataflow HLS block (ap_start/ap_ready/ap_done/ap_continue).
// Counts transactions, measures latency and start-to-start interval, flags
// protocol errors and emits one record per completed transaction.
module nodf_module_status_tracker #(
    parameter int CNT_W = 32,
    parameter int DEPTH = 4,
    parameter int OUT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic [1:0]       state,
    output logic [OUT_W-1:0] outstanding,
    output logic [CNT_W-1:0] start_count,
    output logic [CNT_W-1:0] done_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] busy_cycles,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] last_latency,
    output logic [CNT_W-1:0] min_latency,
    output logic [CNT_W-1:0] max_latency,
    output logic [CNT_W-1:0] last_interval,
    output logic             rec_valid,
    output logic [CNT_W-1:0] rec_index,
    output logic [CNT_W-1:0] rec_latency,
    output logic             err_underflow,
    output logic             err_overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY     = 2'd1,
        ST_STALL    = 2'd2,
        ST_FINISHED = 2'd3
    } state_t;

    state_t state_q;

    // Start timestamps of in-flight transactions; outstanding doubles as occupancy.
    logic [CNT_W-1:0] ts_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             last_ts_valid;
    logic [CNT_W-1:0] last_ts;

    // Saturating increment: counters stick at all ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic             frozen;
    logic             start_ev;
    logic             done_ev;
    logic             stall_ev;
    logic             fifo_empty;
    logic             pop;
    logic             bypass;
    logic             underflow;
    logic             room;
    logic             push;
    logic             overflow;
    logic             done_fire;
    logic [OUT_W-1:0] occ_after_pop;
    logic [OUT_W-1:0] out_next;
    logic [CNT_W-1:0] latency;
    logic [CNT_W-1:0] new_done;

    // Event decode: pop precedes push, so a full FIFO still accepts a start on a done cycle.
    always_comb begin
        frozen        = (state_q == ST_FINISHED) || finish;
        start_ev      = ap_start & ap_ready;
        done_ev       = ap_done & ap_continue;
        stall_ev      = ap_done & ~ap_continue;
        fifo_empty    = (outstanding == '0);
        pop           = done_ev & ~fifo_empty;
        bypass        = done_ev & fifo_empty & start_ev;
        underflow     = done_ev & fifo_empty & ~start_ev;
        occ_after_pop = outstanding - OUT_W'(pop);
        room          = (occ_after_pop != OUT_W'(DEPTH));
        push          = start_ev & ~bypass & room;
        overflow      = start_ev & ~bypass & ~room;
        done_fire     = pop | bypass;
        out_next      = occ_after_pop + OUT_W'(push);
        latency       = pop ? (cycle_count - ts_mem[rd_ptr]) : '0;
        new_done      = sat_inc(done_count);
    end

    assign state = state_q;

    // Timestamp storage is plain data; validity is carried by the pointers.
    always_ff @(posedge clock) begin
        if (!frozen && push) begin
            ts_mem[wr_ptr] <= cycle_count;
        end
    end

    // Counters, statistics, records, error flags and state; all frozen once finished.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            outstanding   <= '0;
            last_ts_valid <= 1'b0;
            last_ts       <= '0;
            start_count   <= '0;
            done_count    <= '0;
            cycle_count   <= '0;
            busy_cycles   <= '0;
            stall_cycles  <= '0;
            last_latency  <= '0;
            min_latency   <= '1;
            max_latency   <= '0;
            last_interval <= '0;
            rec_valid     <= 1'b0;
            rec_index     <= '0;
            rec_latency   <= '0;
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
        end else if (frozen) begin
            state_q   <= ST_FINISHED;
            rec_valid <= 1'b0;
        end else begin
            cycle_count <= sat_inc(cycle_count);
            if (outstanding != '0) busy_cycles <= sat_inc(busy_cycles);
            if (stall_ev) stall_cycles <= sat_inc(stall_cycles);

            if (start_ev) begin
                start_count   <= sat_inc(start_count);
                last_ts       <= cycle_count;
                last_ts_valid <= 1'b1;
                if (last_ts_valid) last_interval <= cycle_count - last_ts;
            end

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            outstanding <= out_next;

            if (overflow)  err_overflow  <= 1'b1;
            if (underflow) err_underflow <= 1'b1;

            rec_valid <= done_fire;
            if (done_fire) begin
                done_count   <= new_done;
                rec_index    <= new_done;
                rec_latency  <= latency;
                last_latency <= latency;
                if (latency < min_latency) min_latency <= latency;
                if (latency > max_latency) max_latency <= latency;
            end

            if (stall_ev)             state_q <= ST_STALL;
            else if (out_next != '0)  state_q <= ST_BUSY;
            else                      state_q <= ST_IDLE;
        end
    end

endmodule

// File: tb/tb_nodf_module_status_tracker.sv
// Directed bench for nodf_module_status_tracker with hand-computed expectations.
module tb_nodf_module_status_tracker;

    localparam int CNT_W = 32;
    localparam int DEPTH = 4;
    localparam int OUT_W = $clog2(DEPTH + 1);

    logic             clock;
    logic             reset;
    logic             ap_start;
    logic             ap_ready;
    logic             ap_done;
    logic             ap_continue;
    logic             finish;
    logic [1:0]       state;
    logic [OUT_W-1:0] outstanding;
    logic [CNT_W-1:0] start_count;
    logic [CNT_W-1:0] done_count;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] busy_cycles;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] last_latency;
    logic [CNT_W-1:0] min_latency;
    logic [CNT_W-1:0] max_latency;
    logic [CNT_W-1:0] last_interval;
    logic             rec_valid;
    logic [CNT_W-1:0] rec_index;
    logic [CNT_W-1:0] rec_latency;
    logic             err_underflow;
    logic             err_overflow;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    nodf_module_status_tracker #(.CNT_W(CNT_W), .DEPTH(DEPTH), .OUT_W(OUT_W)) dut (
        .clock(clock), .reset(reset),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_continue(ap_continue), .finish(finish),
        .state(state), .outstanding(outstanding),
        .start_count(start_count), .done_count(done_count),
        .cycle_count(cycle_count), .busy_cycles(busy_cycles),
        .stall_cycles(stall_cycles), .last_latency(last_latency),
        .min_latency(min_latency), .max_latency(max_latency),
        .last_interval(last_interval), .rec_valid(rec_valid),
        .rec_index(rec_index), .rec_latency(rec_latency),
        .err_underflow(err_underflow), .err_overflow(err_overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset       = 1'b0;
        ap_start    = 1'b0;
        ap_ready    = 1'b0;
        ap_done     = 1'b0;
        ap_continue = 1'b1;
        finish      = 1'b0;
        #12;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic set_start(input logic v);
        ap_start = v;
        ap_ready = v;
    endtask

    initial begin
        reset = 1'b0; ap_start = 1'b0; ap_ready = 1'b0;
        ap_done = 1'b0; ap_continue = 1'b1; finish = 1'b0;
        #23;
        check("rst_state", 32'(state), 0);
        check("rst_outstanding", 32'(outstanding), 0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_min_latency", min_latency, 32'hFFFF_FFFF);
        check("rst_max_latency", max_latency, 0);
        check("rst_rec_valid", 32'(rec_valid), 0);
        check("rst_errs", 32'({err_underflow, err_overflow}), 0);

        // Single transaction of latency 5
        do_reset();
        set_start(1'b1); tick(); set_start(1'b0);
        check("t1_outstanding", 32'(outstanding), 1);
        check("t1_state_busy", 32'(state), 1);
        check("t1_cycle_count", cycle_count, 1);
        for (int i = 0; i < 4; i++) tick();
        ap_done = 1'b1; tick(); ap_done = 1'b0;
        check("t1_rec_valid", 32'(rec_valid), 1);
        check("t1_rec_index", rec_index, 1);
        check("t1_rec_latency", rec_latency, 5);
        check("t1_last_latency", last_latency, 5);
        check("t1_min", min_latency, 5);
        check("t1_max", max_latency, 5);
        check("t1_outstanding0", 32'(outstanding), 0);
        check("t1_state_idle", 32'(state), 0);
        check("t1_busy_cycles", busy_cycles, 5);
        check("t1_cycle_count6", cycle_count, 6);
        tick();
        check("t1_rec_pulse_end", 32'(rec_valid), 0);

        // Three overlapping transactions: starts at 0,2,4, dones at 8,9,10
        do_reset();
        for (int t = 0; t <= 10; t++) begin
            set_start(t == 0 || t == 2 || t == 4);
            ap_done = (t >= 8);
            tick();
            if (t == 2) check("t2_interval_first", last_interval, 2);
            if (t == 4) check("t2_outstanding_peak", 32'(outstanding), 3);
            if (t == 8) begin
                check("t2_lat_a", rec_latency, 8);
                check("t2_idx_a", rec_index, 1);
            end
            if (t == 9) check("t2_lat_b", rec_latency, 7);
            if (t == 10) begin
                check("t2_lat_c", rec_latency, 6);
                check("t2_idx_c", rec_index, 3);
            end
        end
        set_start(1'b0); ap_done = 1'b0;
        check("t2_min", min_latency, 6);
        check("t2_max", max_latency, 8);
        check("t2_last", last_latency, 6);
        check("t2_interval", last_interval, 2);
        check("t2_outstanding0", 32'(outstanding), 0);
        check("t2_start_count", start_count, 3);

        // Stall for three cycles then accept
        do_reset();
        set_start(1'b1); tick(); set_start(1'b0);
        ap_done = 1'b1; ap_continue = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("t3_state_stall", 32'(state), 2);
            check("t3_stall_cycles", stall_cycles, 32'(i));
            check("t3_no_done", done_count, 0);
        end
        ap_continue = 1'b1; tick(); ap_done = 1'b0;
        check("t3_done_count", done_count, 1);
        check("t3_rec_latency", rec_latency, 4);
        check("t3_stall_final", stall_cycles, 3);
        check("t3_state_idle", 32'(state), 0);
        tick();
        check("t3_done_once", done_count, 1);

        // Underflow then overflow
        do_reset();
        ap_done = 1'b1; tick(); ap_done = 1'b0;
        check("t4_underflow", 32'(err_underflow), 1);
        check("t4_done_zero", done_count, 0);
        check("t4_no_rec", 32'(rec_valid), 0);
        check("t4_no_overflow_yet", 32'(err_overflow), 0);
        set_start(1'b1);
        for (int i = 0; i < 5; i++) tick();
        set_start(1'b0);
        check("t4_start_count", start_count, 5);
        check("t4_outstanding", 32'(outstanding), 4);
        check("t4_overflow", 32'(err_overflow), 1);
        tick();
        check("t4_overflow_sticky", 32'(err_overflow), 1);

        // Same-cycle start and done with empty FIFO
        do_reset();
        set_start(1'b1); ap_done = 1'b1; tick();
        set_start(1'b0); ap_done = 1'b0;
        check("t5_rec_valid", 32'(rec_valid), 1);
        check("t5_rec_latency", rec_latency, 0);
        check("t5_min", min_latency, 0);
        check("t5_done_count", done_count, 1);
        check("t5_outstanding", 32'(outstanding), 0);
        check("t5_no_underflow", 32'(err_underflow), 0);

        // Finish freezes everything; async reset clears it
        do_reset();
        set_start(1'b1); tick(); set_start(1'b0);
        finish = 1'b1; tick(); finish = 1'b0;
        check("t6_state_fin", 32'(state), 3);
        set_start(1'b1); ap_done = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        set_start(1'b0); ap_done = 1'b0;
        check("t6_state_absorb", 32'(state), 3);
        check("t6_start_frozen", start_count, 1);
        check("t6_done_frozen", done_count, 0);
        check("t6_outstanding_frozen", 32'(outstanding), 1);
        check("t6_rec_held0", 32'(rec_valid), 0);
        #2 reset = 1'b0;
        #1;
        check("t6_async_state", 32'(state), 0);
        check("t6_async_start", start_count, 0);
        check("t6_async_outstanding", 32'(outstanding), 0);
        check("t6_async_min", min_latency, 32'hFFFF_FFFF);
        check("t6_async_cycle", cycle_count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
